// File: rtl/ldpc_3gpp_enc_src_pack.sv
// Packs pIN_W-bit source beats into pDAT_W-bit words for the encoder matrix register; 1-cycle beat-to-write latency.
// ordy drops only while zero-filling a short block; iclkena low freezes all state and outputs.
module ldpc_3gpp_enc_src_pack #(
  parameter int pDAT_W = 8,
  parameter int pIN_W  = 2,
  parameter int pZC_W  = 8
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic [pZC_W-1:0]  izc_words,
  input  logic              ival,
  input  logic              isop,
  input  logic              ieop,
  input  logic [pIN_W-1:0]  idat,
  output logic              ordy,
  output logic              owrite,
  output logic              owstart,
  output logic [pDAT_W-1:0] owdat,
  output logic              odone
);

  localparam int BPW = pDAT_W / pIN_W;
  localparam int KW  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {IDLE, PACK, FILL} state_t;

  state_t            state, nxt;
  logic [pZC_W-1:0]  n, widx;
  logic [KW-1:0]     k;
  logic [pDAT_W-1:0] sbuf;

  logic              acc, start, beat, full, emit_beat, last_beat, fill_last;
  logic [pZC_W-1:0]  nsel, eff_n, eff_w;
  logic [KW-1:0]     eff_k;
  logic [pDAT_W-1:0] wrd;

  // An isop beat restarts the block from scratch, so its slot/word/size come from the new block.
  always_comb begin
    acc       = ival & ordy & iclkena;
    start     = acc & isop;
    beat      = acc & (isop | (state == PACK));
    nsel      = (izc_words == '0) ? pZC_W'(1) : izc_words;
    eff_k     = start ? '0 : k;
    eff_w     = start ? '0 : widx;
    eff_n     = start ? nsel : n;
    wrd       = start ? '0 : sbuf;
    wrd[int'(eff_k)*pIN_W +: pIN_W] = idat;
    full      = (eff_k == KW'(BPW - 1));
    emit_beat = beat & (full | ieop);
    last_beat = (eff_w == eff_n - pZC_W'(1));
    fill_last = (widx == n - pZC_W'(1));
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset)       state <= IDLE;
    else if (iclkena) state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, PACK: begin
        if (emit_beat)  nxt = last_beat ? IDLE : (ieop ? FILL : PACK);
        else if (beat)  nxt = PACK;
      end
      FILL:    nxt = fill_last ? IDLE : FILL;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ordy = (state != FILL);
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      owrite  <= 1'b0;
      owstart <= 1'b0;
      odone   <= 1'b0;
      owdat   <= '0;
      n       <= '0;
      widx    <= '0;
      k       <= '0;
      sbuf    <= '0;
    end else if (iclkena) begin
      owrite  <= 1'b0;
      owstart <= 1'b0;
      odone   <= 1'b0;
      if (beat) begin
        n <= eff_n;
        if (emit_beat) begin
          owrite  <= 1'b1;
          owstart <= (eff_w == '0);
          odone   <= last_beat;
          owdat   <= wrd;
          widx    <= eff_w + pZC_W'(1);
          k       <= '0;
          sbuf    <= '0;
        end else begin
          widx <= eff_w;
          k    <= eff_k + KW'(1);
          sbuf <= wrd;
        end
      end else if (state == FILL) begin
        owrite  <= 1'b1;
        owstart <= (widx == '0);
        odone   <= fill_last;
        owdat   <= '0;
        widx    <= widx + pZC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ldpc_3gpp_enc_src_pack.sv
// Directed bench for ldpc_3gpp_enc_src_pack with pDAT_W=8, pIN_W=2, pZC_W=8.
module tb_ldpc_3gpp_enc_src_pack;

  logic       iclk, ireset, iclkena;
  logic [7:0] izc_words;
  logic       ival, isop, ieop;
  logic [1:0] idat;
  logic       ordy, owrite, owstart, odone;
  logic [7:0] owdat;

  int checks = 0;
  int errs   = 0;
  int wr_cnt = 0;
  int base;

  ldpc_3gpp_enc_src_pack #(.pDAT_W(8), .pIN_W(2), .pZC_W(8)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .izc_words(izc_words),
    .ival(ival), .isop(isop), .ieop(ieop), .idat(idat),
    .ordy(ordy), .owrite(owrite), .owstart(owstart), .owdat(owdat), .odone(odone)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  always @(posedge iclk) if (owrite && iclkena && !ireset) wr_cnt <= wr_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic send(input logic s, input logic e, input logic [1:0] d);
    ival = 1'b1; isop = s; ieop = e; idat = d;
    tick();
    ival = 1'b0; isop = 1'b0; ieop = 1'b0; idat = 2'd0;
  endtask

  task automatic expw(input string tag, input logic st, input logic dn, input logic [7:0] dat);
    check({tag, "_write"}, owrite, 1'b1);
    check({tag, "_wstart"}, owstart, st);
    check({tag, "_done"}, odone, dn);
    check({tag, "_wdat"}, owdat, dat);
  endtask

  logic [1:0] d1 [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
  logic [1:0] d6 [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] n6 [4] = '{8'd1, 8'd0, 8'd1, 8'd1};

  initial begin
    ireset = 1'b1; iclkena = 1'b1; izc_words = 8'd0;
    ival = 1'b0; isop = 1'b0; ieop = 1'b0; idat = 2'd0;
    tick(); tick();
    check("rst_rdy", ordy, 1'b1);
    check("rst_write", owrite, 1'b0);
    check("rst_wstart", owstart, 1'b0);
    check("rst_done", odone, 1'b0);
    check("rst_wdat", owdat, 8'h00);
    ireset = 1'b0;
    tick();

    // Nominal two-word block
    izc_words = 8'd2;
    for (int i = 0; i < 8; i++) begin
      send(i == 0, i == 7, d1[i]);
      if (i == 3)      expw("nom_w0", 1'b1, 1'b0, 8'hE4);
      else if (i == 7) expw("nom_w1", 1'b0, 1'b1, 8'h1B);
      else             check("nom_nowrite", owrite, 1'b0);
    end
    tick();
    check("nom_idle", owrite, 1'b0);

    // Early eop with zero fill
    izc_words = 8'd3;
    for (int i = 0; i < 5; i++) begin
      send(i == 0, i == 4, 2'd3);
      if (i == 3) expw("eop_w0", 1'b1, 1'b0, 8'hFF);
    end
    expw("eop_w1", 1'b0, 1'b0, 8'h03);
    check("eop_fill_rdy", ordy, 1'b0);
    tick();
    expw("eop_w2", 1'b0, 1'b1, 8'h00);
    check("eop_end_rdy", ordy, 1'b1);
    tick();
    check("eop_idle", owrite, 1'b0);

    // Abort by isop in PACK
    izc_words = 8'd2;
    send(1'b1, 1'b0, 2'd1); check("abt_a0", owrite, 1'b0);
    send(1'b0, 1'b0, 2'd1); check("abt_a1", owrite, 1'b0);
    send(1'b0, 1'b0, 2'd1); check("abt_a2", owrite, 1'b0);
    send(1'b1, 1'b0, 2'd2); check("abt_b0", owrite, 1'b0);
    send(1'b0, 1'b0, 2'd3); check("abt_b1", owrite, 1'b0);
    send(1'b0, 1'b0, 2'd0); check("abt_b2", owrite, 1'b0);
    send(1'b0, 1'b0, 2'd1);
    expw("abt_w0", 1'b1, 1'b0, 8'h4E);

    // Clock-enable hold at the word boundary
    izc_words = 8'd1;
    send(1'b1, 1'b0, 2'd1);
    send(1'b0, 1'b0, 2'd2);
    send(1'b0, 1'b0, 2'd3);
    send(1'b0, 1'b1, 2'd0);
    expw("hold_w", 1'b1, 1'b1, 8'h39);
    base = wr_cnt;
    iclkena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expw("hold_frz", 1'b1, 1'b1, 8'h39);
    end
    iclkena = 1'b1;
    tick();
    check("hold_release", owrite, 1'b0);
    check("hold_count", wr_cnt - base, 1);

    // Reset mid-block
    izc_words = 8'd2;
    send(1'b1, 1'b0, 2'd1);
    send(1'b0, 1'b0, 2'd2);
    send(1'b0, 1'b0, 2'd3);
    #2 ireset = 1'b1;
    #1;
    check("mrst_write", owrite, 1'b0);
    check("mrst_wdat", owdat, 8'h00);
    check("mrst_done", odone, 1'b0);
    check("mrst_rdy", ordy, 1'b1);
    tick();
    ireset = 1'b0;
    base = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 1'b0, 2'd3);
      check("mrst_nosop", owrite, 1'b0);
    end
    tick();
    check("mrst_count", wr_cnt - base, 0);

    // Excess beats after the final word are dropped
    izc_words = 8'd1;
    send(1'b1, 1'b0, 2'd1);
    send(1'b0, 1'b0, 2'd1);
    send(1'b0, 1'b0, 2'd1);
    send(1'b0, 1'b0, 2'd1);
    expw("exc_w", 1'b1, 1'b1, 8'h55);
    send(1'b0, 1'b0, 2'd1); check("exc_drop0", owrite, 1'b0);
    send(1'b0, 1'b0, 2'd2); check("exc_drop1", owrite, 1'b0);

    // Back-to-back single-beat blocks (N=0 treated as 1)
    for (int i = 0; i < 4; i++) begin
      izc_words = n6[i];
      send(1'b1, 1'b1, d6[i]);
      expw("b2b", 1'b1, 1'b1, {6'd0, d6[i]});
    end
    tick();
    check("b2b_idle", owrite, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
